// File: rtl/sbox_pipe.sv
// sbox_pipe: multi-lane AES SubBytes / InvSubBytes with a
// registered, back-pressurable valid/ready pipeline.
module sbox_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter bit ENABLE_INV  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [0:8*LANES-1] message,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [0:8*LANES-1] crypte,
  output logic               busy
);

  localparam int W = 8 * LANES;
  localparam int P = PIPE_STAGES;

  localparam logic [0:2047] FWD_T = {
    64'h637c777bf26b6fc5, 64'h3001672bfed7ab76,
    64'hca82c97dfa5947f0, 64'hadd4a2af9ca472c0,
    64'hb7fd9326363ff7cc, 64'h34a5e5f171d83115,
    64'h04c723c31896059a, 64'h071280e2eb27b275,
    64'h09832c1a1b6e5aa0, 64'h523bd6b329e32f84,
    64'h53d100ed20fcb15b, 64'h6acbbe394a4c58cf,
    64'hd0efaafb434d3385, 64'h45f9027f503c9fa8,
    64'h51a3408f929d38f5, 64'hbcb6da2110fff3d2,
    64'hcd0c13ec5f974417, 64'hc4a77e3d645d1973,
    64'h60814fdc222a9088, 64'h46eeb814de5e0bdb,
    64'he0323a0a4906245c, 64'hc2d3ac629195e479,
    64'he7c8376d8dd54ea9, 64'h6c56f4ea657aae08,
    64'hba78252e1ca6b4c6, 64'he8dd741f4bbd8b8a,
    64'h703eb5664803f60e, 64'h613557b986c11d9e,
    64'he1f8981169d98e94, 64'h9b1e87e9ce5528df,
    64'h8ca1890dbfe64268, 64'h41992d0fb054bb16
  };

  localparam logic [0:2047] INV_T = {
    64'h52096ad53036a538, 64'hbf40a39e81f3d7fb,
    64'h7ce339829b2fff87, 64'h348e4344c4dee9cb,
    64'h547b9432a6c2233d, 64'hee4c950b42fac34e,
    64'h082ea16628d924b2, 64'h765ba2496d8bd125,
    64'h72f8f66486689816, 64'hd4a45ccc5d65b692,
    64'h6c704850fdedb9da, 64'h5e154657a78d9d84,
    64'h90d8ab008cbcd30a, 64'hf7e45805b8b34506,
    64'hd02c1e8fca3f0f02, 64'hc1afbd0301138a6b,
    64'h3a9111414f67dcea, 64'h97f2cfcef0b4e673,
    64'h96ac7422e7ad3585, 64'he2f937e81c75df6e,
    64'h47f11a711d29c589, 64'h6fb7620eaa18be1b,
    64'hfc563e4bc6d27920, 64'h9adbc0fe78cd5af4,
    64'h1fdda8338807c731, 64'hb11210592780ec5f,
    64'h60517fa919b54a0d, 64'h2de57a9f93c99cef,
    64'ha0e03b4dae2af5b0, 64'hc8ebbb3c83539961,
    64'h172b047eba77d626, 64'he169146355210c7d
  };

  function automatic logic [7:0] lut(
    input logic [0:2047] tbl,
    input logic [7:0]    b
  );
    return tbl[{b, 3'b000} +: 8];
  endfunction

  logic [P-1:0] v;
  logic [P-1:0] mode;
  logic [P-1:0] wr;
  logic [0:W-1] data [P];
  logic [0:W-1] sub;

  always_comb begin
    sub = '0;
    for (int k = 0; k < LANES; k++) begin
      if (ENABLE_INV && in_inv)
        sub[8*k +: 8] = lut(INV_T, message[8*k +: 8]);
      else
        sub[8*k +: 8] = lut(FWD_T, message[8*k +: 8]);
    end
  end

  // Stage s can load if it or any stage after it is empty,
  // or the output drains this cycle; bubbles collapse.
  always_comb begin
    logic run;
    run = out_ready;
    wr  = '0;
    for (int s = P - 1; s >= 0; s--) begin
      run   = run | ~v[s];
      wr[s] = run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= '0;
      mode <= '0;
      for (int s = 0; s < P; s++)
        data[s] <= '0;
    end else begin
      if (wr[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          data[0] <= sub;
          mode[0] <= in_inv;
        end
      end
      for (int s = 1; s < P; s++) begin
        if (wr[s]) begin
          v[s] <= v[s-1];
          if (v[s-1]) begin
            data[s] <= data[s-1];
            mode[s] <= mode[s-1];
          end
        end
      end
    end
  end

  assign in_ready  = rst_n & wr[0];
  assign out_valid = v[P-1];
  assign out_inv   = mode[P-1];
  assign crypte    = data[P-1];
  assign busy      = |v;

endmodule

// File: tb/tb_sbox_pipe.sv
// tb_sbox_pipe: randomized scoreboard bench for sbox_pipe,
// reference S-box derived from GF(2^8) inverse + affine map.
module tb_sbox_pipe;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [0:31]  message;
  logic         out_valid;
  logic         out_ready;
  logic         out_inv;
  logic [0:31]  crypte;
  logic         busy;

  logic         a_in_valid;
  logic         a_in_ready;
  logic         a_in_inv;
  logic [0:127] a_message;
  logic         a_out_valid;
  logic         a_out_inv;
  logic [0:127] a_crypte;
  logic         a_busy;

  logic         b_in_valid;
  logic         b_in_ready;
  logic         b_in_inv;
  logic [0:7]   b_message;
  logic         b_out_valid;
  logic         b_out_inv;
  logic [0:7]   b_crypte;
  logic         b_busy;

  logic         side_ready;
  logic         man_ready;
  logic         rnd_mode;
  logic         rnd_bit;
  logic [0:31]  exp_cur;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [0:31] d;
    logic        i;
  } exp_t;

  exp_t q[$];

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  sbox_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .message(message),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inv(out_inv), .crypte(crypte), .busy(busy)
  );

  sbox_pipe #(
    .LANES(16), .PIPE_STAGES(3), .ENABLE_INV(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .message(a_message),
    .out_valid(a_out_valid), .out_ready(side_ready),
    .out_inv(a_out_inv), .crypte(a_crypte), .busy(a_busy)
  );

  sbox_pipe #(
    .LANES(1), .PIPE_STAGES(1), .ENABLE_INV(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .message(b_message),
    .out_valid(b_out_valid), .out_ready(side_ready),
    .out_inv(b_out_inv), .crypte(b_crypte), .busy(b_busy)
  );

  assign out_ready = rnd_mode ? rnd_bit : man_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1 rnd_bit = ($urandom_range(9) < 7);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] req
  );
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] b,
    input int         n
  );
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_model();
    logic [7:0] y;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3)
        ^ rotl(y, 4) ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [0:31] sub4(
    input logic [0:31] m,
    input logic        iv
  );
    logic [0:31] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = iv ? inv_t[m[8*k +: 8]]
                       : fwd_t[m[8*k +: 8]];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk)
    if (rst_n && in_valid && in_ready)
      q.push_back('{d: exp_cur, i: in_inv});

  logic        prev_stall;
  logic [0:31] prev_crypte;
  logic        prev_inv;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(out_valid), 128'(1'b1));
        chk("hold_data", 128'(crypte), 128'(prev_crypte));
        chk("hold_inv", 128'(out_inv), 128'(prev_inv));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL spurious_beat: got %h want none",
                   crypte);
        end else begin
          e = q.pop_front();
          chk("beat_data", 128'(crypte), 128'(e.d));
          chk("beat_inv", 128'(out_inv), 128'(e.i));
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_crypte = crypte;
      prev_inv    = out_inv;
    end
  end

  logic        pv;
  logic [0:31] pm;
  logic        pi;

  always @(negedge clk) begin
    if (rst_n && pv)
      assert (in_valid && message == pm && in_inv == pi)
        else $error("input beat changed before acceptance");
    pv = rst_n && in_valid && !in_ready;
    pm = message;
    pi = in_inv;
  end

  // ---------------- stimulus tasks ----------------
  // All tasks start and end at posedge + #1.
  task automatic send(
    input logic [0:31] m,
    input logic        iv,
    input logic [0:31] e
  );
    int n;
    n        = 0;
    in_valid = 1'b1;
    message  = m;
    in_inv   = iv;
    exp_cur  = e;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: got no in_ready want 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic lat_main(
    input string       nm,
    input logic [0:31] m,
    input logic        iv,
    input logic [0:31] e
  );
    int lat;
    lat      = 0;
    in_valid = 1'b1;
    message  = m;
    in_inv   = iv;
    exp_cur  = e;
    do begin
      @(posedge clk);
      lat++;
      #1 in_valid = 1'b0;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    chk({nm, "_lat"}, 128'(lat), 128'(2));
    chk({nm, "_data"}, 128'(crypte), 128'(e));
    chk({nm, "_inv"}, 128'(out_inv), 128'(iv));
    @(posedge clk);
    #1;
  endtask

  task automatic lat_a(
    input logic [0:127] m,
    input logic         iv,
    input logic [0:127] e
  );
    int lat;
    lat = 0;
    chk("a_in_ready", 128'(a_in_ready), 128'(1'b1));
    a_in_valid = 1'b1;
    a_message  = m;
    a_in_inv   = iv;
    do begin
      @(posedge clk);
      lat++;
      #1 a_in_valid = 1'b0;
      @(negedge clk);
    end while (!a_out_valid && lat < 20);
    chk("a_lat", 128'(lat), 128'(3));
    chk("a_data", 128'(a_crypte), e);
    chk("a_inv", 128'(a_out_inv), 128'(iv));
    @(posedge clk);
    #1;
    chk("a_busy_idle", 128'(a_busy), 128'(1'b0));
  endtask

  task automatic lat_b(
    input logic [0:7] m,
    input logic       iv,
    input logic [0:7] e
  );
    int lat;
    lat = 0;
    chk("b_in_ready", 128'(b_in_ready), 128'(1'b1));
    b_in_valid = 1'b1;
    b_message  = m;
    b_in_inv   = iv;
    do begin
      @(posedge clk);
      lat++;
      #1 b_in_valid = 1'b0;
      @(negedge clk);
    end while (!b_out_valid && lat < 20);
    chk("b_lat", 128'(lat), 128'(1));
    chk("b_data", 128'(b_crypte), 128'(e));
    chk("b_inv", 128'(b_out_inv), 128'(iv));
    @(posedge clk);
    #1;
    chk("b_busy_idle", 128'(b_busy), 128'(1'b0));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, 128'(q.size()), 128'(0));
    @(negedge clk);
    chk({nm, "_busy_low"}, 128'(busy), 128'(1'b0));
    chk({nm, "_valid_low"}, 128'(out_valid), 128'(1'b0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [0:31]  m;
    logic [0:31]  mi;
    logic [0:127] ma;
    logic [0:127] ea;
    logic [7:0]   bb;
    logic         iv;
    int           t0;

    build_model();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_inv     = 1'b0;
    message    = '0;
    exp_cur    = '0;
    man_ready  = 1'b1;
    rnd_mode   = 1'b0;
    side_ready = 1'b1;
    a_in_valid = 1'b0;
    a_in_inv   = 1'b0;
    a_message  = '0;
    b_in_valid = 1'b0;
    b_in_inv   = 1'b0;
    b_message  = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_crypte", 128'(crypte), 128'(0));
    chk("rst_out_inv", 128'(out_inv), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1;

    lat_main("fwd_vec", 32'h000153FF, 1'b0, 32'h637CED16);
    lat_main("inv_vec", 32'h637CED16, 1'b1, 32'h000153FF);

    // alternating modes back-to-back, one beat per clock
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      m  = $urandom;
      iv = 1'(i);
      send(m, iv, sub4(m, iv));
    end
    chk("alt_rate", 128'(cyc - t0), 128'(8));
    drain("alt");

    // exhaustive sweep with random back-pressure and gaps
    rnd_mode = 1'b1;
    for (int x = 0; x < 256; x++) begin
      for (int k = 0; k < 4; k++) begin
        m[8*k +: 8]  = 8'(x + 64 * k);
        mi[8*k +: 8] = fwd_t[8'(x + 64 * k)];
      end
      send(m, 1'b0, sub4(m, 1'b0));
      send(mi, 1'b1, m);
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 200; i++) begin
      m  = $urandom;
      iv = 1'($urandom_range(1));
      send(m, iv, sub4(m, iv));
    end
    rnd_mode = 1'b0;
    drain("sweep");

    // 8-beat stream with a 5-cycle mid-stream stall
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          m  = $urandom;
          iv = 1'($urandom_range(1));
          send(m, iv, sub4(m, iv));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 man_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
        chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
        chk("bp_busy", 128'(busy), 128'(1'b1));
        @(posedge clk);
        #1 man_ready = 1'b1;
      end
    join
    drain("bp");

    // reset with two beats in flight
    man_ready = 1'b0;
    m = $urandom | 32'h01010101;
    send(m, 1'b1, sub4(m, 1'b1));
    m = $urandom;
    send(m, 1'b0, sub4(m, 1'b0));
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(1'b0));
    chk("mid_rst_busy", 128'(busy), 128'(1'b0));
    chk("mid_rst_crypte", 128'(crypte), 128'(0));
    chk("mid_rst_inv", 128'(out_inv), 128'(1'b0));
    chk("mid_rst_ready", 128'(in_ready), 128'(1'b0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    man_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    lat_main("after_rst", 32'h00000000, 1'b0, 32'h63636363);
    drain("end");

    // parameter corners, inverse disabled
    for (int k = 0; k < 16; k++) begin
      ma[8*k +: 8] = 8'h53;
      ea[8*k +: 8] = 8'hED;
    end
    lat_a(ma, 1'b1, ea);
    ma = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 16; k++)
      ea[8*k +: 8] = fwd_t[ma[8*k +: 8]];
    lat_a(ma, 1'b0, ea);

    lat_b(8'h53, 1'b1, 8'hED);
    bb = 8'($urandom);
    lat_b(bb, 1'b1, fwd_t[bb]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
